// File: rtl/pkt2msg_arbiter_pkg.sv
// Shared constants for the packet-to-message arbiter slice: default widths and
// the legacy EMPTY/FULL state encodings.
package pkt2msg_arbiter_pkg;

  localparam int unsigned FLIT_WIDTH_DEFAULT        = 8;
  localparam int unsigned MAX_PACKET_LENGHT_DEFAULT = 3;
  localparam int unsigned N_BITS_REQ_DEFAULT        = 2;

  // Two-bit encoding leaves spare codes; any of them recovers to EMPTY.
  localparam logic [1:0] ST_EMPTY = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/pkt2msg_arbiter_rr.sv
// Purely combinational round-robin arbiter: first requester at or after ptr_i,
// wrapping at N_REQ (which need not be a power of two).
module rr_arbiter
  import pkt2msg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned N_BITS_REQ = N_BITS_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_BITS_REQ-1:0] ptr_i,
  output logic [N_REQ-1:0]      grant_o,
  output logic [N_BITS_REQ-1:0] idx_o,
  output logic                  any_o
);

  int unsigned             pos;
  logic [N_BITS_REQ-1:0]   cand;

  always_comb begin
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      cand = N_BITS_REQ'(pos);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    grant_o = any_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/pkt2msg_arbiter.sv
// Shares one packet-to-message stage among N_REQ flits buffers: round-robin
// grant, single holding register, request/grant handshake downstream.
module pkt2msg_arbiter
  import pkt2msg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ             = 4,
  parameter int unsigned N_BITS_REQ        = N_BITS_REQ_DEFAULT,
  parameter int unsigned FLIT_WIDTH        = FLIT_WIDTH_DEFAULT,
  parameter int unsigned MAX_PACKET_LENGHT = MAX_PACKET_LENGHT_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_REQ-1:0]                        r_pkt_to_msg_i,
  output logic [N_REQ-1:0]                        g_pkt_to_msg_o,
  input  logic [N_REQ*MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_link_i,
  input  logic [N_REQ*MAX_PACKET_LENGHT-1:0]      pkt_sel_i,
  output logic                                    r_msg_o,
  input  logic                                    g_msg_i,
  output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] msg_link_o,
  output logic [MAX_PACKET_LENGHT-1:0]            msg_sel_o,
  output logic [N_BITS_REQ-1:0]                   msg_src_o
);

  localparam int unsigned LINK_W = MAX_PACKET_LENGHT * FLIT_WIDTH;

  logic [1:0]                   state_q, state_d;
  logic [N_BITS_REQ-1:0]        rr_ptr_q, rr_ptr_d;
  logic [LINK_W-1:0]            link_q, link_d;
  logic [MAX_PACKET_LENGHT-1:0] sel_q, sel_d;
  logic [N_BITS_REQ-1:0]        src_q, src_d;

  logic [N_REQ-1:0]             arb_grant;
  logic [N_BITS_REQ-1:0]        win;
  logic                         arb_any;
  logic                         can_take;
  logic                         grant_en;
  logic [LINK_W-1:0]            link_mux;
  logic [MAX_PACKET_LENGHT-1:0] sel_mux;

  rr_arbiter #(
    .N_REQ      (N_REQ),
    .N_BITS_REQ (N_BITS_REQ)
  ) u_rr (
    .req_i   (r_pkt_to_msg_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (win),
    .any_o   (arb_any)
  );

  // Grants are gated by reset so buffers never clear while the stage is held.
  always_comb begin
    can_take       = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && g_msg_i);
    grant_en       = rst && can_take && arb_any;
    g_pkt_to_msg_o = grant_en ? arb_grant : '0;
  end

  always_comb begin
    link_mux = '0;
    sel_mux  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win == N_BITS_REQ'(k)) begin
        link_mux = pkt_link_i[k*LINK_W +: LINK_W];
        sel_mux  = pkt_sel_i[k*MAX_PACKET_LENGHT +: MAX_PACKET_LENGHT];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    link_d   = link_q;
    sel_d    = sel_q;
    src_d    = src_q;
    if (grant_en) begin
      state_d  = ST_FULL;
      link_d   = link_mux;
      sel_d    = sel_mux;
      src_d    = win;
      rr_ptr_d = (win == N_BITS_REQ'(N_REQ - 1)) ? '0 : win + 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = ST_EMPTY;
        ST_FULL:  state_d = g_msg_i ? ST_EMPTY : ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      link_q   <= '0;
      sel_q    <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      link_q   <= link_d;
      sel_q    <= sel_d;
      src_q    <= src_d;
    end
  end

  // Stale link data stays visible after draining; only the flit mask is cleared.
  always_comb begin
    r_msg_o    = (state_q == ST_FULL);
    msg_link_o = link_q;
    msg_sel_o  = (state_q == ST_FULL) ? sel_q : '0;
    msg_src_o  = src_q;
  end

endmodule
